// File: rtl/serial_pattern_detector.sv
// Serial bit-pattern detector: compares the last W accepted bits against a
// programmable pattern and pulses y on each match. A saturating counter tallies the matches.
module serial_pattern_detector #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             x,
    input  logic [W-1:0]     pattern,
    input  logic             overlap,
    input  logic             clr_cnt,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int FILL_W = $clog2(W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(W - 1);

    logic [W-2:0]       hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               y_q, y_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_base;
    logic               sat_q, sat_d;
    logic [W-1:0]       cand;
    logic               match;

    always_comb begin
        cand   = {hist_q, x};
        match  = in_valid && (fill_q == FILL_MAX) && (cand == pattern);
        hist_d = hist_q;
        fill_d = fill_q;
        if (in_valid) begin
            hist_d = cand[W-2:0];
            // Non-overlapping search needs W fresh bits after every match.
            if (match && !overlap)
                fill_d = '0;
            else if (fill_q != FILL_MAX)
                fill_d = fill_q + 1'b1;
        end
        y_d = match;

        // The clear takes effect first, so a match on the same edge counts as 1.
        cnt_base = clr_cnt ? '0 : cnt_q;
        cnt_d    = cnt_base;
        if (match && (cnt_base != {CNT_W{1'b1}}))
            cnt_d = cnt_base + 1'b1;
        sat_d = &cnt_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
            y_q    <= 1'b0;
            cnt_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            y_q    <= y_d;
            cnt_q  <= cnt_d;
            sat_q  <= sat_d;
        end
    end

    assign y         = y_q;
    assign match_cnt = cnt_q;
    assign cnt_sat   = sat_q;

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Directed-vector bench for serial_pattern_detector. Three instances cover the
// W=4/CNT_W=8, W=4/CNT_W=2 and W=2 configurations.
module tb_serial_pattern_detector;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic x = 1'b0;
    logic overlap = 1'b0;
    logic clr_cnt = 1'b0;
    logic [3:0] pattern4 = 4'b1111;
    logic [1:0] pattern2 = 2'b01;

    logic       y_a, sat_a, y_b, sat_b, y_c, sat_c;
    logic [7:0] cnt_a, cnt_c;
    logic [1:0] cnt_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_pattern_detector #(.W(4), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .pattern(pattern4),
        .overlap(overlap), .clr_cnt(clr_cnt), .y(y_a), .match_cnt(cnt_a), .cnt_sat(sat_a));

    serial_pattern_detector #(.W(4), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .pattern(pattern4),
        .overlap(overlap), .clr_cnt(clr_cnt), .y(y_b), .match_cnt(cnt_b), .cnt_sat(sat_b));

    serial_pattern_detector #(.W(2), .CNT_W(8)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .pattern(pattern2),
        .overlap(overlap), .clr_cnt(clr_cnt), .y(y_c), .match_cnt(cnt_c), .cnt_sat(sat_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    // One clock: inputs change on the falling edge, outputs sampled 1 ns after the rising edge.
    task automatic step(input logic v, input logic b, input logic clr);
        @(negedge clk);
        in_valid = v;
        x        = b;
        clr_cnt  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        clr_cnt = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic y_of(input int sel);
        case (sel)
            0:       return y_a;
            1:       return y_b;
            default: return y_c;
        endcase
    endfunction

    // Applies n bits (bits[n-1] first) and checks y after each; optional idle gap after each bit.
    task automatic run_seq(input string tag, input int sel, input int n,
                           input logic [15:0] bits, input logic [15:0] exp_y, input logic gap);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, bits[i], 1'b0);
            chk($sformatf("%s y bit%0d", tag, n - i), {31'b0, y_of(sel)}, {31'b0, exp_y[i]});
            if (gap) begin
                step(1'b0, ~bits[i], 1'b0);
                chk($sformatf("%s gap y bit%0d", tag, n - i), {31'b0, y_of(sel)}, 32'd0);
            end
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #12;
        chk("reset y", {31'b0, y_a}, 32'd0);
        chk("reset cnt", {24'b0, cnt_a}, 32'd0);
        chk("reset sat", {31'b0, sat_a}, 32'd0);
        do_reset();

        pattern4 = 4'b1111;
        overlap  = 1'b0;
        run_seq("ones nov", 0, 8, 16'b1111_1111, 16'b0001_0001, 1'b0);
        chk("ones nov cnt", {24'b0, cnt_a}, 32'd2);

        do_reset();
        overlap = 1'b1;
        run_seq("ones ov", 0, 8, 16'b1111_1111, 16'b0001_1111, 1'b0);
        chk("ones ov cnt", {24'b0, cnt_a}, 32'd5);

        do_reset();
        pattern4 = 4'b1011;
        overlap  = 1'b1;
        run_seq("1011 ov", 0, 7, 16'b101_1011, 16'b000_1001, 1'b0);
        chk("1011 ov cnt", {24'b0, cnt_a}, 32'd2);

        do_reset();
        overlap = 1'b0;
        run_seq("1011 nov", 0, 7, 16'b101_1011, 16'b000_1000, 1'b0);
        chk("1011 nov cnt", {24'b0, cnt_a}, 32'd1);

        do_reset();
        overlap = 1'b1;
        run_seq("1011 gap", 0, 7, 16'b101_1011, 16'b000_1001, 1'b1);
        chk("1011 gap cnt", {24'b0, cnt_a}, 32'd2);

        // Saturating 2-bit counter
        do_reset();
        pattern4 = 4'b1111;
        overlap  = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b1, 1'b0);
            chk($sformatf("sat cnt bit%0d", i), {30'b0, cnt_b},
                (i < 4) ? 32'd0 : (i >= 6) ? 32'd3 : 32'(i - 3));
        end
        chk("sat flag", {31'b0, sat_b}, 32'd1);
        step(1'b1, 1'b1, 1'b1);
        chk("clr+match cnt", {30'b0, cnt_b}, 32'd1);
        chk("clr+match sat", {31'b0, sat_b}, 32'd0);
        chk("clr+match y", {31'b0, y_b}, 32'd1);
        step(1'b0, 1'b0, 1'b1);
        chk("clr only cnt", {30'b0, cnt_b}, 32'd0);
        chk("clr only y", {31'b0, y_b}, 32'd0);
        step(1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-sequence
        do_reset();
        overlap = 1'b0;
        run_seq("pre-rst", 0, 7, 16'b111_1111, 16'b000_1000, 1'b0);
        chk("pre-rst cnt", {24'b0, cnt_a}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst cnt", {24'b0, cnt_a}, 32'd0);
        chk("async rst y", {31'b0, y_a}, 32'd0);
        chk("async rst sat", {31'b0, sat_a}, 32'd0);
        @(posedge clk);
        #1;
        chk("in rst cnt", {24'b0, cnt_a}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_seq("post-rst", 0, 4, 16'b1111, 16'b0001, 1'b0);
        chk("post-rst cnt", {24'b0, cnt_a}, 32'd1);

        // W=2, pattern 01
        do_reset();
        overlap = 1'b0;
        run_seq("w2 nov", 2, 4, 16'b0101, 16'b0101, 1'b0);
        chk("w2 nov cnt", {24'b0, cnt_c}, 32'd2);
        do_reset();
        overlap = 1'b1;
        run_seq("w2 ov", 2, 4, 16'b0101, 16'b0101, 1'b0);
        chk("w2 ov cnt", {24'b0, cnt_c}, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_pattern_detector.md
# serial_pattern_detector

Parametrised serial bit-pattern detector: samples one bit per qualified clock, compares the last `W` accepted bits against a run-time programmable pattern, and pulses `y` on every match. It generalises our fixed four-ones detector with programmable pattern and width, a valid qualifier, selectable overlapping or non-overlapping matching, and a saturating match counter. It sits directly on a serial input stream and feeds match events to downstream control or status logic.

## Interface
- `W`, default 4: pattern length in bits, legal range 2..32.
- `CNT_W`, default 8: width of the match counter, legal range 1..32.

- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  qualifies `x`; bit is accepted only when high.
- `x`  input  1  serial data bit.
- `pattern`  input  W  target sequence; `pattern[W-1]` is the first bit of the sequence, `pattern[0]` the last.
- `overlap`  input  1  1 = overlapping matches allowed, 0 = search restarts after each match.
- `clr_cnt`  input  1  synchronous clear of `match_cnt` and `cnt_sat`.
- `y`  output  1  registered one-cycle match pulse.
- `match_cnt`  output  CNT_W  number of matches since reset or last clear; saturating.
- `cnt_sat`  output  1  high while `match_cnt` is all ones.

## Operation
- Internal state: history register `hist[W-2:0]` (the last W-1 accepted bits, newest in bit 0) and fill counter `fill` (0..W-1, number of accepted bits currently eligible for a match).
- Accepted bit (`in_valid`=1): candidate = {hist, x}. Match iff `fill` == W-1 and candidate == `pattern`.
- On every accepted bit: `hist` <= {hist[W-3:0], x} (for W=2, `hist` <= x).
- Fill update on accepted bit: match and `overlap`=0 -> `fill` <= 0; otherwise `fill` <= min(`fill`+1, W-1).
- `in_valid`=0: `hist`, `fill` hold; no match evaluated; `y` <= 0.
- `y` <= match result of the current edge; never high two cycles for one accepted bit.
- `pattern` and `overlap` are sampled on each accepted bit only; changes never clear `hist` or `fill` and take effect on the next accepted bit.
- Counter: on match, `match_cnt` <= `match_cnt`+1 unless already all ones (holds). `cnt_sat` mirrors `match_cnt` == all ones.
- `clr_cnt`=1 with no match: `match_cnt` <= 0, `cnt_sat` <= 0. `clr_cnt`=1 coincident with a match: `match_cnt` <= 1 (clear applied first, then the match counts), `cnt_sat` <= (CNT_W==1).
- `clr_cnt` does not affect `hist`, `fill` or `y`.
- With W=4, `pattern`=4'b1111, `overlap`=0, `in_valid`=1 the block reproduces the legacy four-ones detector, except `y` is registered (one cycle later).

## Timing
- Reset (asynchronous assert, released synchronously by the environment): `hist`=0, `fill`=0, `y`=0, `match_cnt`=0, `cnt_sat`=0. Reset asserted mid-sequence discards all partial progress; a full W accepted bits are needed after release before the first match.
- Latency: completing bit sampled at edge N -> `y` high during cycle N to N+1, `match_cnt` updated at the same edge N.
- First possible match: the W-th accepted bit after reset.
- Non-overlapping: minimum spacing between matches is W accepted bits. Overlapping: matches may occur on consecutive accepted bits (for example, all-ones pattern).
- No combinational path from inputs to outputs.

## Test plan
- W=4, `pattern`=1111, `overlap`=0, `in_valid`=1, eight 1s -> `y` pulses after bits 4 and 8 only; `match_cnt`=2.
- Same stimulus with `overlap`=1 -> `y` pulses after bits 4, 5, 6, 7 and 8; `match_cnt`=5.
- `pattern`=1011, `overlap`=1, stream 1,0,1,1,0,1,1 -> pulses after bits 4 and 7; with `overlap`=0 -> pulse after bit 4 only (bit 7 completes only 3 fresh bits); insert `in_valid`=0 gaps between bits -> identical match positions, `y` low during gaps.
- `CNT_W`=2, all-ones pattern, overlap, ten 1s -> `match_cnt` 1, 2, 3 then holds at 3, `cnt_sat`=1; `clr_cnt` coincident with a match -> `match_cnt`=1, `cnt_sat`=0.
- Assert `rst` asynchronously after three 1s (pattern 1111), release, then one 1 -> no match; three more 1s -> match after the 4th post-reset bit. All outputs are 0 while `rst` is high.
- W=2, `pattern`=01, stream 0,1,0,1 -> matches after bits 2 and 4 in both overlap modes.
